// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time_keeper block.
//   - mode_e     : operating mode encoding driven on the top-level `mode` port
//   - MAX_MIN    : last BCD value of a minutes counter
//   - MAX_HR     : last BCD value of an hours counter
//   - ALARM_RST  : alarm time loaded at reset, packed BCD HH:MM
//   - bcd2_inc() : wrap-aware increment of a packed two-digit BCD value
package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    localparam logic [7:0]  MAX_MIN   = 8'h59;
    localparam logic [7:0]  MAX_HR    = 8'h23;
    localparam logic [15:0] ALARM_RST = 16'h0700;

    // Next value of a two-digit BCD counter that wraps to 00 after lim.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] value, input logic [7:0] lim);
        logic [7:0] w_res;
        if (value == lim) begin
            w_res = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            w_res = {value[7:4] + 4'd1, 4'd0};
        end else begin
            w_res = {value[7:4], value[3:0] + 4'd1};
        end
        return w_res;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit packed BCD counter, 00..MAX_VAL, wrapping to 00.
// Parameters:
//   MAX_VAL  last value before wrap (BCD)
//   RST_VAL  value loaded by reset (BCD)
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   i_inc    advance by one this cycle
//   i_clear  force to 00 this cycle (wins over i_inc)
//   o_next   value the register takes at the coming edge
//   o_carry  high in the cycle an increment wraps MAX_VAL -> 00
module bcd2_counter
    import time_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_clear,
    output logic [7:0] o_next,
    output logic       o_carry
);

    logic [7:0] r_value;

    // Next value is exported so the parent can register derived outputs
    // (display, alarm compare) on the same edge the count changes.
    always_comb begin
        o_next = r_value;
        if (i_clear) begin
            o_next = 8'h00;
        end else if (i_inc) begin
            o_next = bcd2_inc(r_value, MAX_VAL);
        end
    end

    assign o_carry = i_inc && !i_clear && (r_value == MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= RST_VAL;
        end else begin
            r_value <= o_next;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: time-of-day core of the alarm clock.
// Divides clk to a one-second tick, keeps HH:MM in BCD and seconds in binary,
// and supports setting the time and (optionally) an alarm.
// Optional feature macro: TIME_KEEPER_ALARM_EN (SET_ALARM mode, alarm storage,
// trigger and `alarm` output). Without it `alarm` is 0 and `alarm_off` is ignored.
// Parameters:
//   CLK_HZ     clk cycles per second
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   mode_btn   pulse, advances mode RUN -> SET_TIME [-> SET_ALARM] -> RUN
//   inc_min    pulse, increments minutes of the item being set
//   inc_hr     pulse, increments hours of the item being set
//   alarm_off  pulse, silences the alarm
//   display    packed BCD HH:MM (alarm time while in SET_ALARM)
//   sec_tick   one-cycle pulse per elapsed second
//   mode       current mode (0 RUN, 1 SET_TIME, 2 SET_ALARM)
//   alarm      alarm active, level
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_btn,
    input  logic        inc_min,
    input  logic        inc_hr,
    input  logic        alarm_off,
    output logic [15:0] display,
    output logic        sec_tick,
    output logic [1:0]  mode,
    output logic        alarm
);

    localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    mode_e         r_mode;
    mode_e         w_mode_next;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic          r_sec_tick;
    logic [15:0]   r_display;
    logic [15:0]   w_display_next;

    logic       w_set_time;
    logic       w_presc_wrap;
    logic       w_sec_wrap;
    logic       w_min_inc;
    logic       w_min_carry;
    logic       w_hr_inc;
    logic       w_hr_carry_unused;
    logic [7:0] w_min_next;
    logic [7:0] w_hr_next;

    always_comb begin
        w_mode_next = r_mode;
        if (mode_btn) begin
            case (r_mode)
                MODE_RUN:      w_mode_next = MODE_SET_TIME;
`ifdef TIME_KEEPER_ALARM_EN
                MODE_SET_TIME: w_mode_next = MODE_SET_ALARM;
`else
                MODE_SET_TIME: w_mode_next = MODE_RUN;
`endif
                default:       w_mode_next = MODE_RUN;
            endcase
        end
    end

    assign w_set_time = (r_mode == MODE_SET_TIME);

    // Time keeps running in SET_ALARM; only SET_TIME freezes it.
    assign w_presc_wrap = !w_set_time && (r_presc == PRESC_LAST);
    assign w_sec_wrap   = w_presc_wrap && (r_sec == 6'd59);

    // A mode_btn pulse swallows any simultaneous increment.
    assign w_min_inc = w_sec_wrap || (w_set_time && inc_min && !mode_btn);
    // Minute wraps while setting never carry into hours.
    assign w_hr_inc  = (w_min_carry && !w_set_time) || (w_set_time && inc_hr && !mode_btn);

    bcd2_counter #(
        .MAX_VAL (MAX_MIN),
        .RST_VAL (8'h00)
    ) u_min (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_min_inc),
        .i_clear (1'b0),
        .o_next  (w_min_next),
        .o_carry (w_min_carry)
    );

    bcd2_counter #(
        .MAX_VAL (MAX_HR),
        .RST_VAL (8'h00)
    ) u_hr (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_hr_inc),
        .i_clear (1'b0),
        .o_next  (w_hr_next),
        .o_carry (w_hr_carry_unused)
    );

`ifdef TIME_KEEPER_ALARM_EN
    logic       w_alm_edit;
    logic [7:0] w_amin_next;
    logic [7:0] w_ahr_next;
    logic       w_amin_carry_unused;
    logic       w_ahr_carry_unused;
    logic       w_trigger;
    logic       r_alarm;

    assign w_alm_edit = (r_mode == MODE_SET_ALARM) && !mode_btn;

    bcd2_counter #(
        .MAX_VAL (MAX_MIN),
        .RST_VAL (ALARM_RST[7:0])
    ) u_alm_min (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_alm_edit && inc_min),
        .i_clear (1'b0),
        .o_next  (w_amin_next),
        .o_carry (w_amin_carry_unused)
    );

    bcd2_counter #(
        .MAX_VAL (MAX_HR),
        .RST_VAL (ALARM_RST[15:8])
    ) u_alm_hr (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_alm_edit && inc_hr),
        .i_clear (1'b0),
        .o_next  (w_ahr_next),
        .o_carry (w_ahr_carry_unused)
    );

    // Compare against the post-edge time so alarm rises with the display change.
    // Only a running minute carry can trigger; setting the time never does.
    assign w_trigger = (r_mode == MODE_RUN) && w_sec_wrap &&
                       ({w_hr_next, w_min_next} == {w_ahr_next, w_amin_next});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alarm <= 1'b0;
        end else if (alarm_off || mode_btn) begin
            r_alarm <= 1'b0;
        end else if (w_trigger) begin
            r_alarm <= 1'b1;
        end
    end

    assign w_display_next = (w_mode_next == MODE_SET_ALARM) ? {w_ahr_next, w_amin_next}
                                                            : {w_hr_next, w_min_next};
    assign alarm = r_alarm;
`else
    logic w_alarm_off_unused;

    assign w_alarm_off_unused = alarm_off;
    assign w_display_next     = {w_hr_next, w_min_next};
    assign alarm              = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode     <= MODE_RUN;
            r_presc    <= '0;
            r_sec      <= '0;
            r_sec_tick <= 1'b0;
            r_display  <= '0;
        end else begin
            r_mode     <= w_mode_next;
            r_sec_tick <= w_presc_wrap;
            r_display  <= w_display_next;
            if (w_set_time) begin
                r_presc <= '0;
                r_sec   <= '0;
            end else if (w_presc_wrap) begin
                r_presc <= '0;
                r_sec   <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign display  = r_display;
    assign sec_tick = r_sec_tick;
    assign mode     = r_mode;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: self-checking bench for time_keeper with CLK_HZ = 4.
// A behavioural model tracks time as seconds-of-day and the alarm as
// minute-of-day; every cycle all outputs are compared against it, plus
// directed checks for the documented scenarios and a randomized phase.
module tb_time_keeper;

    localparam int unsigned CLK_HZ = 4;
`ifdef TIME_KEEPER_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        mode_btn  = 1'b0;
    logic        inc_min   = 1'b0;
    logic        inc_hr    = 1'b0;
    logic        alarm_off = 1'b0;
    logic [15:0] display;
    logic        sec_tick;
    logic [1:0]  mode;
    logic        alarm;

    time_keeper #(
        .CLK_HZ (CLK_HZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_btn  (mode_btn),
        .inc_min   (inc_min),
        .inc_hr    (inc_hr),
        .alarm_off (alarm_off),
        .display   (display),
        .sec_tick  (sec_tick),
        .mode      (mode),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_ticks = 0;

    // Reference model state
    int m_tod;        // seconds of day, 0..86399
    int m_phase;      // clock cycles into the current second
    int m_mode;       // 0 RUN, 1 SET_TIME, 2 SET_ALARM
    int m_alarm_min;  // alarm minute of day
    bit m_tick;
    bit m_alarm;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int min_of_day);
        int h;
        int mi;
        h  = min_of_day / 60;
        mi = min_of_day % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
    endfunction

    function automatic logic [15:0] exp_display();
        return (m_mode == 2) ? to_bcd(m_alarm_min) : to_bcd(m_tod / 60);
    endfunction

    task automatic model_reset();
        m_tod       = 0;
        m_phase     = 0;
        m_mode      = 0;
        m_alarm_min = 7 * 60;
        m_tick      = 1'b0;
        m_alarm     = 1'b0;
    endtask

    task automatic model_step(input logic mb, input logic im, input logic ih, input logic ao);
        int h;
        int mi;
        bit fire;
        fire   = 1'b0;
        m_tick = 1'b0;
        if (m_mode == 1) begin
            m_phase = 0;
            m_tod   = m_tod - (m_tod % 60);
            if (!mb) begin
                h  = m_tod / 3600;
                mi = (m_tod / 60) % 60;
                if (im) mi = (mi + 1) % 60;
                if (ih) h = (h + 1) % 24;
                m_tod = h * 3600 + mi * 60;
            end
        end else begin
            if (m_phase == CLK_HZ - 1) begin
                m_phase = 0;
                m_tick  = 1'b1;
                m_tod   = (m_tod + 1) % 86400;
                if (m_mode == 0 && (m_tod % 60) == 0 && (m_tod / 60) == m_alarm_min)
                    fire = ALARM_EN;
            end else begin
                m_phase++;
            end
            if (m_mode == 2 && !mb) begin
                h  = m_alarm_min / 60;
                mi = m_alarm_min % 60;
                if (im) mi = (mi + 1) % 60;
                if (ih) h = (h + 1) % 24;
                m_alarm_min = h * 60 + mi;
            end
        end
        if (ao || mb) m_alarm = 1'b0;
        else if (fire) m_alarm = 1'b1;
        if (mb) begin
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && ALARM_EN) m_mode = 2;
            else m_mode = 0;
        end
    endtask

    task automatic check_all();
        check_eq("display", 32'(display), 32'(exp_display()));
        check_eq("sec_tick", 32'(sec_tick), 32'(m_tick));
        check_eq("mode", 32'(mode), 32'(m_mode));
        check_eq("alarm", 32'(alarm), 32'(m_alarm));
        if (sec_tick === 1'b1) n_ticks++;
    endtask

    // One clock: drive pulses, step the model at the edge, check 1 time unit later.
    task automatic cycle(input logic mb, input logic im, input logic ih, input logic ao);
        mode_btn  = mb;
        inc_min   = im;
        inc_hr    = ih;
        alarm_off = ao;
        @(posedge clk);
        model_step(mb, im, ih, ao);
        #1;
        check_all();
        mode_btn  = 1'b0;
        inc_min   = 1'b0;
        inc_hr    = 1'b0;
        alarm_off = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle, check the immediate reset values, release on negedge.
    task automatic do_reset();
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        check_eq("rst_display", 32'(display), 32'h0);
        check_eq("rst_tick", 32'(sec_tick), 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int first_tick;
        bit seen;

        // Power-on reset
        model_reset();
        #12;
        check_all();
        check_eq("por_mode", 32'(mode), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 240 cycles of RUN: one minute, sixty ticks
        n_ticks = 0;
        idle(240);
        check_eq("run_240_display", 32'(display), 32'h0001);
        check_eq("run_240_ticks", 32'(n_ticks), 32'd60);

        // Set 23:59 then full rollover after 60 seconds
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("set_2359", 32'(display), 32'h2359);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TIME_KEEPER_ALARM_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
`endif
        check_eq("back_to_run", 32'(mode), 32'h0);
        idle(240);
        check_eq("rollover", 32'(display), 32'h0000);

        // Setting wraps: minutes 59 -> 00 without carry, hours 23 -> 00
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("set_2359_b", 32'(display), 32'h2359);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("min_wrap_no_carry", 32'(display), 32'h2300);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("hr_wrap", 32'(display), 32'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("both_inc", 32'(display), 32'h0101);

`ifdef TIME_KEEPER_ALARM_EN
        // Alarm at 00:01 from 00:00
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("alarm_disp_rst", 32'(display), 32'h0700);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("alarm_set", 32'(display), 32'h0001);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (alarm === 1'b1) seen = 1'b1;
        end
        check_eq("alarm_rose", 32'(seen), 32'h1);
        check_eq("alarm_rise_display", 32'(display), 32'h0001);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("alarm_off", 32'(alarm), 32'h0);
`endif

        // mode_btn together with inc_min in SET_TIME
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef TIME_KEEPER_ALARM_EN
        check_eq("btn_and_inc_mode", 32'(mode), 32'h2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
`else
        check_eq("btn_and_inc_mode", 32'(mode), 32'h0);
`endif
        check_eq("btn_and_inc_min", 32'(display), 32'h0003);

        // Reset with the prescaler at 2; first tick four cycles after release
        for (int i = 0; i < 8 && m_phase != 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("phase_reached", 32'(m_phase), 32'd2);
        do_reset();
        first_tick = 0;
        for (int i = 1; i <= 10 && first_tick == 0; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (sec_tick === 1'b1) first_tick = i;
        end
        check_eq("first_tick_after_rst", 32'(first_tick), 32'd4);

        // Randomized pulses against the model
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day core of the alarm clock. Divides the 100 MHz board clock to a one-second tick, keeps hours/minutes in BCD and seconds in binary, and handles time setting and an optional alarm. Its `display` word drives the 16-bit data input of the seven-segment display stage directly. The display stage consumes it as packed BCD HH:MM without further conversion.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock cycles per second; the bench uses 4.

Ports:
- `clk`  in  1  100 MHz system clock
- `rst`  in  1  asynchronous, active-low reset
- `mode_btn`  in  1  single-cycle pulse (debounced upstream); advances mode
- `inc_min`  in  1  single-cycle pulse; increments minutes of the item being set
- `inc_hr`  in  1  single-cycle pulse; increments hours of the item being set
- `alarm_off`  in  1  single-cycle pulse; silences alarm
- `display`  out  16  BCD {H tens, H ones, M tens, M ones}
- `sec_tick`  out  1  one-cycle pulse per elapsed second
- `mode`  out  2  current mode: 0 RUN, 1 SET_TIME, 2 SET_ALARM
- `alarm`  out  1  alarm active, level

## Operation
- Reset (async assert, sync release):
  - time 00:00, seconds 0, prescaler 0
  - mode RUN
  - `sec_tick` 0, `alarm` 0
  - alarm time 07:00
- Prescaler: counts 0..CLK_HZ-1 and wraps.
- Seconds:
  - Seconds increment only in RUN, at the edge where the prescaler wraps.
  - Seconds count 0..59. A wrap from 59 to 0 generates a minute carry.
- Minute/hour counters:
  - Minutes count BCD 00..59. A wrap generates an hour carry.
  - Hours count BCD 00..23.
  - 23:59:59 rolls over to 00:00:00.
  - Digits never leave 0..9; no other BCD codes ever appear.
- Mode state machine, transitions on `mode_btn`: RUN -> SET_TIME -> SET_ALARM -> RUN.
- SET_TIME:
  - Prescaler and seconds are held at 0.
  - `inc_min` increments minutes, 59 -> 00, with no carry into hours.
  - `inc_hr` increments hours, 23 -> 00.
- Leaving SET_TIME restarts counting from seconds 0 and prescaler 0.
- SET_ALARM:
  - Time keeps running.
  - `inc_min`/`inc_hr` edit the alarm time with the same wrap rules.
  - `display` shows the alarm time; in every other mode it shows the current time.
- Alarm trigger:
  - Fires in RUN only, on the edge where a minute carry makes the current time equal to the alarm time.
  - Setting the time to equal the alarm time never triggers it.
  - `alarm` stays high until `alarm_off` or `mode_btn`.
- Simultaneous events:
  - `mode_btn` together with `inc_*`: mode advances, the increment is ignored.
  - `inc_min` together with `inc_hr`: both apply.
  - `alarm_off` in the trigger cycle: `alarm` stays 0.
  - `inc_*` in RUN is ignored.

## Timing
- All state is registered. `display` and `mode` are register outputs, updated at the same edge that samples the causing pulse.
- `sec_tick` is high for exactly one cycle, the cycle after the prescaler-wrap edge. The seconds count updates at that same edge.
- `alarm` rises at the edge where `display` changes to the alarm value.
- Reset mid-second: all outputs take their reset values immediately. The partial second is discarded and no `sec_tick` is produced.

## Configuration
- `TIME_KEEPER_ALARM_EN` defined: SET_ALARM mode, alarm registers, trigger and `alarm` output are all present, as described above.
- `TIME_KEEPER_ALARM_EN` not defined:
  - Mode cycles RUN -> SET_TIME -> RUN; value 2 never appears on `mode`.
  - `alarm` is tied to 0 and `alarm_off` is ignored.
  - No alarm storage is synthesized.

## Structure
- Shared package `time_pkg` holds:
  - mode encodings MODE_RUN / MODE_SET_TIME / MODE_SET_ALARM
  - BCD limits MAX_MIN = 8'h59, MAX_HR = 8'h23
  - reset alarm value 16'h0700
- One sub-module, `bcd2_counter`:
  - two-digit BCD counter
  - parameter: max value
  - inputs: inc, clear
  - output: carry, pulsed on wrap
- `time_keeper` instantiates `bcd2_counter` four times: current minutes, current hours, alarm minutes, alarm hours.

## Test plan
All scenarios use CLK_HZ=4.
- Reset released -> `display` 16'h0000, `mode` 0, `alarm` 0. After 240 cycles in RUN -> `display` 16'h0001, exactly 60 `sec_tick` pulses.
- SET_TIME: 23 `inc_hr` and 59 `inc_min` pulses, then 2 `mode_btn`, then 60 seconds -> `display` 16'h0000 (full rollover).
- SET_TIME with minutes at 59: one `inc_min` -> 16'h2300 from 16'h2359 (no hour carry). One `inc_hr` -> 16'h0000.
- Alarm set to 00:01, run from 00:00 -> `alarm` rises at the edge `display` becomes 16'h0001. An `alarm_off` pulse -> `alarm` 0 at the next edge.
- `mode_btn` and `inc_min` in the same cycle while in SET_TIME -> `mode` becomes 2, minutes unchanged.
- `rst` asserted at prescaler count 2 -> outputs at reset values in the same cycle. After release, the first `sec_tick` arrives 4 cycles later.
